// File: rtl/serial_pad_pkg.sv
// Shared types and constants for the serial pad reader.
// States, protocol widths and NES button bit positions.
package serial_pad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_LOW,
    CLK_HIGH,
    DONE
  } pad_state_t;

  localparam int NES_BITS  = 8;
  localparam int SNES_BITS = 16;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/serial_pad_reader_edge_detect.sv
// Per-channel button register with press/release pulses.
// SERIAL_PAD_DEBOUNCE_EN: accept a frame only if it repeats.
module pad_edge_detect
  import serial_pad_pkg::*;
#(
  parameter int BITS = NES_BITS
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            update,
  input  logic [BITS-1:0] frame,
  output logic [BITS-1:0] buttons,
  output logic [BITS-1:0] pressed,
  output logic [BITS-1:0] released
);

  logic [BITS-1:0] next;

`ifdef SERIAL_PAD_DEBOUNCE_EN
  logic [BITS-1:0] last_frame;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_frame <= '0;
    end else if (update) begin
      last_frame <= frame;
    end
  end

  // An unconfirmed frame leaves the channel untouched.
  assign next = (frame == last_frame) ? frame : buttons;
`else
  assign next = frame;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      buttons  <= '0;
      pressed  <= '0;
      released <= '0;
    end else begin
      pressed  <= '0;
      released <= '0;
      if (update) begin
        buttons  <= next;
        pressed  <= next & ~buttons;
        released <= ~next & buttons;
      end
    end
  end

endmodule

// File: rtl/serial_pad_reader.sv
// Multi-channel NES/SNES pad reader with shared latch/clock.
// SERIAL_PAD_DEBOUNCE_EN enables two-frame confirmation.
module serial_pad_reader
  import serial_pad_pkg::*;
#(
  parameter int CHANNELS        = 2,
  parameter int BITS            = NES_BITS,
  parameter int CLK_HZ          = 50_000_000,
  parameter int POLL_HZ         = 60,
  parameter int HALF_BIT_CYCLES = 300
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [CHANNELS-1:0]      pad_data,
  output logic                     pad_latch,
  output logic                     pad_clock,
  output logic [CHANNELS*BITS-1:0] buttons,
  output logic [CHANNELS*BITS-1:0] pressed,
  output logic [CHANNELS*BITS-1:0] released,
  output logic                     frame_valid,
  output logic                     busy
);

  localparam int POLL_CYCLES = CLK_HZ / POLL_HZ;
  localparam int LATCH_LEN = 2 * HALF_BIT_CYCLES;
  localparam int FRAME_CYCLES =
    LATCH_LEN + 2 * BITS * HALF_BIT_CYCLES + 2;
  localparam int PW = $clog2(POLL_CYCLES);
  localparam int HW = $clog2(LATCH_LEN);
  localparam int KW = (BITS > 1) ? $clog2(BITS) : 1;

  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [HW-1:0] LATCH_LAST = HW'(LATCH_LEN - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_BIT_CYCLES - 1);
  localparam logic [KW-1:0] K_LAST = KW'(BITS - 1);

  generate
    if (POLL_CYCLES <= FRAME_CYCLES) begin : g_poll_chk
      $error("poll period shorter than one pad frame");
    end
  endgenerate

  logic [CHANNELS-1:0] sync_meta;
  logic [CHANNELS-1:0] sync_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta <= '0;
      sync_data <= '0;
    end else begin
      sync_meta <= pad_data;
      sync_data <= sync_meta;
    end
  end

  logic [PW-1:0] poll_cnt;
  logic          tick;

  assign tick = (poll_cnt == POLL_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      poll_cnt <= '0;
    end else if (tick) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  pad_state_t               state;
  logic [HW-1:0]            phase;
  logic [KW-1:0]            bit_idx;
  logic [CHANNELS*BITS-1:0] shift;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      phase       <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      pad_latch   <= 1'b0;
      pad_clock   <= 1'b1;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          // Ticks seen outside IDLE are simply lost.
          if (tick) begin
            state     <= LATCH;
            phase     <= '0;
            pad_latch <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LATCH: begin
          if (phase == LATCH_LAST) begin
            state     <= CLK_LOW;
            phase     <= '0;
            bit_idx   <= '0;
            pad_latch <= 1'b0;
            pad_clock <= 1'b0;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        CLK_LOW: begin
          if (phase == HALF_LAST) begin
            for (int c = 0; c < CHANNELS; c++) begin
              shift[c*BITS + int'(bit_idx)] <= ~sync_data[c];
            end
            state     <= CLK_HIGH;
            phase     <= '0;
            pad_clock <= 1'b1;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        CLK_HIGH: begin
          if (phase == HALF_LAST) begin
            phase <= '0;
            if (bit_idx == K_LAST) begin
              state <= DONE;
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              state     <= CLK_LOW;
              pad_clock <= 1'b0;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          busy        <= 1'b0;
          frame_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic done;

  assign done = (state == DONE);

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      pad_edge_detect #(
        .BITS(BITS)
      ) u_edge (
        .clock   (clock),
        .reset   (reset),
        .update  (done),
        .frame   (shift[c*BITS +: BITS]),
        .buttons (buttons[c*BITS +: BITS]),
        .pressed (pressed[c*BITS +: BITS]),
        .released(released[c*BITS +: BITS])
      );
    end
  endgenerate

endmodule

// File: tb/tb_serial_pad_reader.sv
// Randomised bench for serial_pad_reader with a pad model
// and a frame-level reference of buttons and edge pulses.
module tb_serial_pad_reader;

  localparam int CH   = 2;
  localparam int B    = 8;
  localparam int H    = 4;
  localparam int POLL = 100;
  localparam int FLEN = 2*H + 2*B*H + 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [CH-1:0]     pad_data;
  logic              pad_latch;
  logic              pad_clock;
  logic [CH*B-1:0]   buttons;
  logic [CH*B-1:0]   pressed;
  logic [CH*B-1:0]   released;
  logic              frame_valid;
  logic              busy;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  serial_pad_reader #(
    .CHANNELS       (CH),
    .BITS           (B),
    .CLK_HZ         (1000),
    .POLL_HZ        (10),
    .HALF_BIT_CYCLES(H)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pad_data   (pad_data),
    .pad_latch  (pad_latch),
    .pad_clock  (pad_clock),
    .buttons    (buttons),
    .pressed    (pressed),
    .released   (released),
    .frame_valid(frame_valid),
    .busy       (busy)
  );

  // Pad model: raw line levels, bit idx shifted out LSB first.
  logic [CH-1:0][B-1:0] raw;
  int idx = 0;

  always @(posedge pad_latch) idx = 0;
  always @(posedge pad_clock) if (!pad_latch) idx = idx + 1;

  always_comb begin
    pad_data = '1;
    for (int c = 0; c < CH; c++)
      if (idx < B) pad_data[c] = raw[c][idx];
  end

  int lat_cyc = 0, low_cyc = 0, low_pul = 0;
  int bad_w = 0, idle_act = 0, cur_w = 0;
  logic prev_clk = 1'b1, prev_lat = 1'b0;

  always @(negedge clock) begin
    if (pad_latch === 1'b1 && !prev_lat) begin
      lat_cyc = 0; low_cyc = 0; low_pul = 0; bad_w = 0;
    end
    if (pad_latch === 1'b1) lat_cyc++;
    if (pad_clock === 1'b0) begin
      low_cyc++;
      if (prev_clk) begin low_pul++; cur_w = 0; end
      cur_w++;
    end else if (!prev_clk && cur_w != H) begin
      bad_w++;
    end
    if (busy === 1'b0 && (pad_latch || !pad_clock))
      idle_act++;
    prev_clk = (pad_clock !== 1'b0);
    prev_lat = (pad_latch === 1'b1);
  end

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic [CH-1:0][B-1:0] m_btn;
`ifdef SERIAL_PAD_DEBOUNCE_EN
  logic [CH-1:0][B-1:0] m_last;
`endif

  task automatic model_reset();
    m_btn = '0;
`ifdef SERIAL_PAD_DEBOUNCE_EN
    m_last = '0;
`endif
  endtask

  // Waits for the next frame from a negedge and checks it.
  task automatic run_frame(string tag, int exp_n);
    logic [CH-1:0][B-1:0] eb, ep, er, cap;
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (frame_valid !== 1'b1 && n < exp_n + 20);
    chk({tag, "_latency"}, n, exp_n);
    if (frame_valid !== 1'b1) return;
    for (int c = 0; c < CH; c++) begin
      cap[c] = ~raw[c];
`ifdef SERIAL_PAD_DEBOUNCE_EN
      eb[c] = (cap[c] == m_last[c]) ? cap[c] : m_btn[c];
      m_last[c] = cap[c];
`else
      eb[c] = cap[c];
`endif
      ep[c] = eb[c] & ~m_btn[c];
      er[c] = ~eb[c] & m_btn[c];
    end
    m_btn = eb;
    chk({tag, "_buttons"}, 32'(buttons), 32'(eb));
    chk({tag, "_pressed"}, 32'(pressed), 32'(ep));
    chk({tag, "_released"}, 32'(released), 32'(er));
    chk({tag, "_latch_cyc"}, lat_cyc, 2*H);
    chk({tag, "_clk_pulses"}, low_pul, B);
    chk({tag, "_clk_low"}, low_cyc, B*H);
    chk({tag, "_clk_width"}, bad_w, 0);
    @(negedge clock);
    chk({tag, "_pulse_end"},
        {pressed, released, 15'd0, frame_valid}, 32'd0);
  endtask

  initial begin
    int n;
    raw = '1;
    model_reset();
    repeat (5) @(negedge clock);
    chk("rst_latch", 32'(pad_latch), 32'd0);
    chk("rst_clock", 32'(pad_clock), 32'd1);
    chk("rst_buttons", 32'(buttons), 32'd0);
    chk("rst_pulses", 32'({pressed, released}), 32'd0);
    chk("rst_valid", 32'(frame_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    run_frame("unplugged", POLL - 1 + FLEN);
    raw[0] = 8'b1111_1110;
    run_frame("a_press", POLL - 1);
    raw[0] = 8'hFF;
    run_frame("a_release", POLL - 1);

    // Start toggling each frame, then held for two frames.
    for (int i = 0; i < 4; i++) begin
      raw[0] = (i % 2 == 0) ? 8'hF7 : 8'hFF;
      run_frame("start_toggle", POLL - 1);
    end
    raw[0] = 8'hF7;
    run_frame("start_hold1", POLL - 1);
    run_frame("start_hold2", POLL - 1);

    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 2) != 0)
          raw[c] = 8'($urandom);
      run_frame("random", POLL - 1);
    end

    // Abort a frame during its fourth low clock phase.
    raw[0] = 8'h00;
    raw[1] = 8'h5A;
    n = 0;
    while (!(busy === 1'b1 && low_pul == 4) && n < 2*POLL) begin
      @(negedge clock);
      n++;
    end
    chk("abort_reached", 32'(low_pul), 32'd4);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_latch", 32'(pad_latch), 32'd0);
    chk("abort_clock", 32'(pad_clock), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_buttons", 32'(buttons), 32'd0);
    chk("abort_pulses",
        32'({pressed, released, frame_valid}), 32'd0);
    model_reset();
    reset = 1'b0;
    run_frame("after_abort", POLL - 1 + FLEN);
    run_frame("after_abort2", POLL - 1);

    chk("idle_activity", idle_act, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
